// File: rtl/seq_gen.sv
// Serial stimulus transmitter: shifts a latched pattern out LSB-first on w and
// produces z_exp, the expected output of a two-consecutive-ones Mealy detector.
module seq_gen #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LW    = 5,
    parameter int unsigned CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
    input  logic             rpt,
    output logic             w,
    output logic             z_exp,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    pair_count
);

    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_SEND  = 1'b1;
    localparam logic [LW-1:0] LEN_MAX = LW'(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    idx_q, idx_d;
    logic             rpt_q, rpt_d;
    logic             w_q, w_d;
    logic             z_q, z_d;
    logic             prev_w_q, prev_w_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pend_q, pend_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LW-1:0]    len_eff_c;

    // Next-state and output computation; all outputs are registered below.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        sh_d     = sh_q;
        len_d    = len_q;
        idx_d    = idx_q;
        rpt_d    = rpt_q;
        cnt_d    = cnt_q;
        w_d      = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        pend_d   = 1'b0;
        len_eff_c = (len > LEN_MAX) ? LEN_MAX : len;

        if (state_q == S_IDLE) begin
            // A one-shot finish is flagged on the last bit and pulsed here, so done never overlaps busy.
            done_d = pend_q;
            if (start && !stop) begin
                cnt_d = '0;
                if (len_eff_c == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = S_SEND;
                    pat_d   = pattern;
                    sh_d    = pattern;
                    len_d   = len_eff_c;
                    rpt_d   = rpt;
                    idx_d   = '0;
                end
            end
        end else begin
            if (stop) begin
                state_d = S_IDLE;
            end else begin
                w_d    = sh_q[0];
                busy_d = 1'b1;
                if (idx_q == len_q - LW'(1)) begin
                    if (rpt_q) begin
                        idx_d = '0;
                        sh_d  = pat_q;
                    end else begin
                        state_d = S_IDLE;
                        pend_d  = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + LW'(1);
                    sh_d  = sh_q >> 1;
                end
            end
        end

        prev_w_d = w_d;
        z_d      = w_d & prev_w_q;
        if (z_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pat_q    <= '0;
            sh_q     <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            rpt_q    <= 1'b0;
            w_q      <= 1'b0;
            z_q      <= 1'b0;
            prev_w_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            sh_q     <= sh_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            rpt_q    <= rpt_d;
            w_q      <= w_d;
            z_q      <= z_d;
            prev_w_q <= prev_w_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
        end
    end

    assign w          = w_q;
    assign z_exp      = z_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pair_count = cnt_q;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: directed steps plus random traffic, checked each cycle
// against a transfer-level reference model; a CW=2 copy covers saturation.
module tb_seq_gen;

    logic        clk = 1'b0;
    logic        rst, start, stop, rpt;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic        w, z_exp, busy, done;
    logic [7:0]  pair_count;
    logic        s_w, s_z_exp, s_busy, s_done;
    logic [1:0]  s_pair_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: one active transfer described by pattern, length and position.
    bit          m_active, m_pend, m_rpt;
    bit [15:0]   m_pat;
    int          m_len, m_k, m_pairs;
    bit          m_w, m_z, m_busy, m_done;

    always #5 clk = ~clk;

    seq_gen #(.WIDTH(16), .LW(5), .CW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pattern(pattern),
        .len(len), .rpt(rpt), .w(w), .z_exp(z_exp), .busy(busy), .done(done),
        .pair_count(pair_count)
    );

    seq_gen #(.WIDTH(16), .LW(5), .CW(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pattern(pattern),
        .len(len), .rpt(rpt), .w(s_w), .z_exp(s_z_exp), .busy(s_busy), .done(s_done),
        .pair_count(s_pair_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model advance for one rising edge using the inputs present at that edge.
    task automatic model_step();
        bit nw;
        nw = 1'b0;
        m_busy = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            m_active = 0; m_pend = 0; m_pairs = 0; m_w = 0; m_z = 0;
            return;
        end
        if (!m_active) begin
            if (m_pend) m_done = 1'b1;
            m_pend = 0;
            if (start && !stop) begin
                m_pairs = 0;
                m_len = (int'(len) > 16) ? 16 : int'(len);
                if (m_len == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_active = 1; m_k = 0; m_pat = pattern; m_rpt = rpt;
                end
            end
        end else if (stop) begin
            m_active = 0;
        end else begin
            nw = m_pat[m_k];
            m_busy = 1'b1;
            m_k++;
            if (m_k == m_len) begin
                if (m_rpt) m_k = 0;
                else begin m_active = 0; m_pend = 1; end
            end
        end
        m_z = nw & m_w;
        m_w = nw;
        if (m_z) m_pairs++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("w", 32'(w), 32'(m_w));
        chk("z_exp", 32'(z_exp), 32'(m_z));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("pair_count", 32'(pair_count), 32'((m_pairs > 255) ? 255 : m_pairs));
        chk("pair_count_cw2", 32'(s_pair_count), 32'((m_pairs > 3) ? 3 : m_pairs));
    endtask

    task automatic launch(input logic [15:0] p, input logic [4:0] l, input logic r);
        pattern = p; len = l; rpt = r; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; rpt = 1'b0; pattern = '0; len = '0;
        tick(); tick();
        rst = 1'b0;

        // One-shot 0x0036, 8 bits
        launch(16'h0036, 5'd8, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        chk("oneshot_pairs", 32'(pair_count), 32'd2);
        tick();

        // Repeat 0x0005 over 3 bits, ignored start in cycle 5, stop in cycle 6
        launch(16'h0005, 5'd3, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        pattern = 16'hFFFF; len = 5'd16; rpt = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("abort_w", 32'(w), 32'd0);
        chk("abort_pairs", 32'(pair_count), 32'd1);
        tick(); tick();

        // Zero length
        launch(16'hFFFF, 5'd0, 1'b0);
        chk("len0_done", 32'(done), 32'd1);
        tick(); tick();

        // Over-long length clamps to 16
        launch(16'hFFFF, 5'd31, 1'b0);
        for (int i = 0; i < 17; i++) tick();
        chk("len31_pairs", 32'(pair_count), 32'd15);
        tick();

        // start and stop together in IDLE
        stop = 1'b1;
        launch(16'h00FF, 5'd8, 1'b0);
        stop = 1'b0;
        tick();
        chk("startstop_busy", 32'(busy), 32'd0);

        // Saturation of the CW=2 copy
        launch(16'h00FF, 5'd8, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chk("sat_cw2", 32'(s_pair_count), 32'd3);
        chk("sat_cw8", 32'(pair_count), 32'd7);

        // Reset during an active transfer
        launch(16'hFFFF, 5'd16, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        chk("rst_pairs", 32'(pair_count), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            start   = ($urandom_range(3) == 0);
            stop    = ($urandom_range(15) == 0);
            rst     = ($urandom_range(63) == 0);
            rpt     = ($urandom_range(3) == 0);
            pattern = 16'($urandom);
            len     = 5'($urandom_range(31));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
